// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared types, flag indices and canonical-value helpers for
//               the pipelined floating-point adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int FP_MAX_W = 64;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_QNAN,
    SP_INF
  } fp_special_e;

  // Special-value result decided at unpack and carried untouched to pack.
  typedef struct packed {
    fp_special_e kind;
    logic        sign;
    logic        invalid;
  } fp_bypass_t;

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < FP_MAX_W; i++)
      if (i >= man_w - 1 && i < exp_w + man_w) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < FP_MAX_W; i++) begin
      if (i >= man_w && i < exp_w + man_w) v[i] = 1'b1;
      if (i == exp_w + man_w)              v[i] = sign;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_add_pipe_if.sv
// ============================================================================
// Module      : fp_add_pipe_if
// Description : Operand-issue / result-writeback handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_add_pipe_if #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic [2:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_z, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_z, out_flags
  );
endinterface

`default_nettype wire

// File: rtl/fp_lzc.sv
// ============================================================================
// Module      : fp_lzc
// Description : Combinational leading-zero counter; all-zero input gives WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_lzc #(
  parameter int WIDTH = 57,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_pipe.sv
// ============================================================================
// Module      : fp_add_pipe
// Description : 4-stage IEEE-754 adder/subtractor, RNE, flush-to-zero, global stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_add_pipe_if.slave bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 4;
  localparam int SUM_W = MAN_W + 5;
  localparam int LZ_W  = $clog2(SUM_W + 1);
  localparam int EXT_W = EXP_W + 2;
  localparam logic [EXP_W-1:0]    EXP_ONES  = '1;
  localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic [FP_MAX_W-1:0] INF_FULL  = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
  localparam logic [W-2:0]        INF_MAG   = INF_FULL[W-2:0];

  logic advance;
  assign advance      = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = advance;

  // ---------------- stage 1: unpack / classify / order ----------------
  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)       return CLS_ZERO;
    if (e != EXP_ONES) return CLS_NORM;
    if (f == '0)       return CLS_INF;
    return f[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic             w_sa, w_sb, w_swap;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  fp_class_e        w_ca, w_cb;
  fp_bypass_t       w_byp;

  assign w_sa = bus.in_a[W-1];
  assign w_sb = bus.in_b[W-1] ^ bus.in_sub;
  assign w_ca = classify(bus.in_a[W-2:MAN_W], bus.in_a[MAN_W-1:0]);
  assign w_cb = classify(bus.in_b[W-2:MAN_W], bus.in_b[MAN_W-1:0]);
  assign w_ea = (w_ca == CLS_ZERO) ? '0 : bus.in_a[W-2:MAN_W];
  assign w_eb = (w_cb == CLS_ZERO) ? '0 : bus.in_b[W-2:MAN_W];
  assign w_fa = (w_ca == CLS_ZERO) ? '0 : bus.in_a[MAN_W-1:0];
  assign w_fb = (w_cb == CLS_ZERO) ? '0 : bus.in_b[MAN_W-1:0];
  assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};

  always_comb begin
    w_byp = '{SP_NONE, 1'b0, 1'b0};
    if (w_ca == CLS_SNAN || w_cb == CLS_SNAN)      w_byp = '{SP_QNAN, 1'b0, 1'b1};
    else if (w_ca == CLS_QNAN || w_cb == CLS_QNAN) w_byp = '{SP_QNAN, 1'b0, 1'b0};
    else if (w_ca == CLS_INF && w_cb == CLS_INF)
      w_byp = (w_sa != w_sb) ? '{SP_QNAN, 1'b0, 1'b1} : '{SP_INF, w_sa, 1'b0};
    else if (w_ca == CLS_INF)                      w_byp = '{SP_INF, w_sa, 1'b0};
    else if (w_cb == CLS_INF)                      w_byp = '{SP_INF, w_sb, 1'b0};
  end

  logic             r1_valid, r1_sign, r1_zsign, r1_eff_sub;
  logic [EXP_W-1:0] r1_exp_a, r1_exp_b;
  logic [MAN_W:0]   r1_sig_a, r1_sig_b;
  fp_bypass_t       r1_byp;

  // ---------------- stage 2: align with guard/round/sticky ----------------
  logic [EXP_W-1:0] w_d;
  logic [SIG_W-1:0] w_full_b, w_shift, w_sig_b_al;
  logic             w_lost;

  assign w_d      = r1_exp_a - r1_exp_b;
  assign w_full_b = {r1_sig_b, 3'b000};

  always_comb begin
    w_shift    = w_full_b >> w_d;
    w_lost     = |(w_full_b & ~({SIG_W{1'b1}} << w_d));
    w_sig_b_al = {w_shift[SIG_W-1:1], w_shift[0] | w_lost};
    if (32'(w_d) >= 32'(MAN_W + 3))
      w_sig_b_al = {{(SIG_W-1){1'b0}}, |w_full_b};
  end

  logic             r2_valid, r2_sign, r2_zsign, r2_eff_sub;
  logic [EXP_W-1:0] r2_exp;
  logic [SIG_W-1:0] r2_sig_a, r2_sig_b;
  fp_bypass_t       r2_byp;

  // ---------------- stage 3: add / subtract ----------------
  logic [SUM_W-1:0] w_sum;
  assign w_sum = r2_eff_sub ? ({1'b0, r2_sig_a} - {1'b0, r2_sig_b})
                            : ({1'b0, r2_sig_a} + {1'b0, r2_sig_b});

  logic             r3_valid, r3_sign, r3_zsign;
  logic [EXP_W-1:0] r3_exp;
  logic [SUM_W-1:0] r3_sum;
  fp_bypass_t       r3_byp;

  // ---------------- stage 4: normalise / round / pack ----------------
  logic [LZ_W-1:0]  w_lz;
  logic [SIG_W-1:0] w_norm;
  logic [EXT_W-1:0] w_exp_n, w_exp_r;
  logic [MAN_W+1:0] w_mant;
  logic [MAN_W-1:0] w_frac;
  logic             w_rnd, w_inexact, w_ovf, w_unf;
  logic [W-1:0]     w_z;
  logic [2:0]       w_flags;

  fp_lzc #(.WIDTH(SUM_W), .CNT_W(LZ_W)) u_lzc (.value(r3_sum), .count(w_lz));

  always_comb begin
    if (r3_sum[SUM_W-1]) begin
      w_norm  = {r3_sum[SUM_W-1:2], r3_sum[1] | r3_sum[0]};
      w_exp_n = {2'b00, r3_exp} + EXT_W'(1);
    end else begin
      // A count of 1 means the hidden bit already sits in place.
      w_norm  = r3_sum[SUM_W-2:0] << (w_lz - LZ_W'(1));
      w_exp_n = {2'b00, r3_exp} + EXT_W'(1) - EXT_W'(w_lz);
    end
    w_inexact = |w_norm[2:0];
    w_rnd     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant    = {1'b0, w_norm[SIG_W-1:3]} + (MAN_W+2)'(w_rnd);
    w_exp_r   = w_exp_n + EXT_W'(w_mant[MAN_W+1]);
    w_frac    = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
    w_ovf     = !w_exp_r[EXT_W-1] && (w_exp_r >= {2'b00, EXP_ONES});
    w_unf     = w_exp_r[EXT_W-1] || (w_exp_r == '0);

    w_z     = '0;
    w_flags = '0;
    if (r3_byp.kind == SP_QNAN) begin
      w_z                   = QNAN;
      w_flags[FLAG_INVALID] = r3_byp.invalid;
    end else if (r3_byp.kind == SP_INF) begin
      w_z = {r3_byp.sign, INF_MAG};
    end else if (r3_sum == '0) begin
      w_z = {r3_zsign, {(W-1){1'b0}}};
    end else if (w_ovf) begin
      w_z                    = {r3_sign, INF_MAG};
      w_flags[FLAG_OVERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]  = 1'b1;
    end else if (w_unf) begin
      w_z                   = {r3_sign, {(W-1){1'b0}}};
      w_flags[FLAG_INEXACT] = 1'b1;
    end else begin
      w_z                   = {r3_sign, w_exp_r[EXP_W-1:0], w_frac};
      w_flags[FLAG_INEXACT] = w_inexact;
    end
  end

  // ---------------- pipeline registers ----------------
  logic         r_out_valid;
  logic [W-1:0] r_out_z;
  logic [2:0]   r_out_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r3_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_flags <= '0;
    end else if (advance) begin
      r1_valid    <= bus.in_valid;
      r2_valid    <= r1_valid;
      r3_valid    <= r2_valid;
      r_out_valid <= r3_valid;
      if (r3_valid) begin
        r_out_z     <= w_z;
        r_out_flags <= w_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      r1_sign    <= w_swap ? w_sb : w_sa;
      r1_zsign   <= w_sa & w_sb;
      r1_eff_sub <= w_sa ^ w_sb;
      r1_exp_a   <= w_swap ? w_eb : w_ea;
      r1_exp_b   <= w_swap ? w_ea : w_eb;
      r1_sig_a   <= w_swap ? {w_eb != '0, w_fb} : {w_ea != '0, w_fa};
      r1_sig_b   <= w_swap ? {w_ea != '0, w_fa} : {w_eb != '0, w_fb};
      r1_byp     <= w_byp;

      r2_sign    <= r1_sign;
      r2_zsign   <= r1_zsign;
      r2_eff_sub <= r1_eff_sub;
      r2_exp     <= r1_exp_a;
      r2_sig_a   <= {r1_sig_a, 3'b000};
      r2_sig_b   <= w_sig_b_al;
      r2_byp     <= r1_byp;

      r3_sign    <= r2_sign;
      r3_zsign   <= r2_zsign;
      r3_exp     <= r2_exp;
      r3_sum     <= w_sum;
      r3_byp     <= r2_byp;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;
  assign bus.out_flags = r_out_flags;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
// ============================================================================
// Module      : tb_fp_add_pipe
// Description : Directed self-checking bench for fp_add_pipe (binary64 and binary32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_pipe_if #(.EXP_W(11), .MAN_W(52)) bus64 ();
  fp_add_pipe_if #(.EXP_W(8),  .MAN_W(23)) bus32 ();

  fp_add_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));
  fp_add_pipe #(.EXP_W(8),  .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    n_checks++;
    assert (obs === expd) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        output logic [63:0] z, output logic [2:0] fl, output int lat);
    @(posedge clk); #1;
    bus64.in_valid = 1'b1;
    bus64.in_a     = a;
    bus64.in_b     = b;
    bus64.in_sub   = sub;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    lat = 1;
    while (!bus64.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    z  = bus64.out_z;
    fl = bus64.out_flags;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] z;
    logic [2:0]  fl;
  } vec_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    vec_t        vecs[15];
    logic [63:0] z;
    logic [2:0]  fl;
    int          lat, issued, got, stalls, spurious;

    bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_sub = 1'b0; bus64.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_sub = 1'b0; bus32.out_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus64.out_valid), 64'd0);
    check("rst_out_z",     bus64.out_z,          64'd0);
    check("rst_out_flags", 64'(bus64.out_flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus64.in_ready), 64'd1);

    // ---- directed vectors ----
    vecs[0]  = '{64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h4000000000000000, 3'b000};
    vecs[1]  = '{64'h4008000000000000, 64'h4008000000000000, 1'b1, 64'h0000000000000000, 3'b000};
    vecs[2]  = '{64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 3'b001};
    vecs[3]  = '{64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 3'b011};
    vecs[4]  = '{64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, 64'h7FF8000000000000, 3'b100};
    vecs[5]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 3'b100};
    vecs[6]  = '{64'h7FF8000000000000, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 3'b000};
    vecs[7]  = '{64'h7FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h7FF0000000000000, 3'b000};
    vecs[8]  = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000, 3'b000};
    vecs[9]  = '{64'h4000000000000000, 64'h4008000000000000, 1'b1, 64'hBFF0000000000000, 3'b000};
    vecs[10] = '{64'h3FF0000000000000, 64'h3FE0000000000000, 1'b1, 64'h3FE0000000000000, 3'b000};
    vecs[11] = '{64'h0000000000000001, 64'h3FF0000000000000, 1'b0, 64'h3FF0000000000000, 3'b000};
    vecs[12] = '{64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000002, 3'b001};
    vecs[13] = '{64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 64'h7FF8000000000000, 3'b100};
    vecs[14] = '{64'h0000000000000000, 64'h8000000000000000, 1'b0, 64'h0000000000000000, 3'b000};

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, z, fl, lat);
      check($sformatf("vec%0d_z", i),       z,           vecs[i].z);
      check($sformatf("vec%0d_flags", i),   64'(fl),     64'(vecs[i].fl));
      check($sformatf("vec%0d_latency", i), 64'(lat),    64'd4);
    end
    @(posedge clk); #1;

    // ---- backpressure: 8 ops k+1.0, out_ready low for 5 cycles ----
    issued = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(posedge clk); #1;
      bus64.in_valid  = (issued < 8);
      bus64.in_a      = $realtobits(real'(issued + 1));
      bus64.in_b      = 64'h3FF0000000000000;
      bus64.in_sub    = 1'b0;
      bus64.out_ready = !(cyc >= 4 && cyc < 9);
      @(negedge clk);
      if (bus64.out_valid && !bus64.out_ready) begin
        stalls++;
        check("bp_in_ready_low", 64'(bus64.in_ready), 64'd0);
        check("bp_z_held",       bus64.out_z,         $realtobits(real'(got + 2)));
      end
      if (bus64.in_valid && bus64.in_ready) issued++;
      if (bus64.out_valid && bus64.out_ready) begin
        check($sformatf("bp_result%0d", got), bus64.out_z, $realtobits(real'(got + 2)));
        got++;
      end
    end
    bus64.in_valid  = 1'b0;
    bus64.out_ready = 1'b1;
    check("bp_stall_cycles", 64'(stalls), 64'd5);
    check("bp_issued",       64'(issued), 64'd8);
    check("bp_received",     64'(got),    64'd8);
    repeat (2) @(posedge clk);
    #1;
    check("bp_no_duplicate", 64'(bus64.out_valid), 64'd0);

    // ---- reset with 3 ops in flight ----
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
    bus64.in_valid  = 1'b1;
    bus64.in_a      = 64'h3FF0000000000000;
    bus64.in_b      = 64'h3FF0000000000000;
    repeat (3) @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rmf_out_valid_before", 64'(bus64.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rmf_out_valid_async", 64'(bus64.out_valid), 64'd0);
    check("rmf_out_z_async",     bus64.out_z,           64'd0);
    check("rmf_out_flags_async", 64'(bus64.out_flags),  64'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    bus64.out_ready = 1'b1;
    spurious = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus64.out_valid !== 1'b0) spurious++;
    end
    check("rmf_no_stale", 64'(spurious), 64'd0);

    // ---- binary32 instance ----
    @(posedge clk); #1;
    bus32.in_valid = 1'b1;
    bus32.in_a     = 32'h3F800000;
    bus32.in_b     = 32'h40000000;
    bus32.in_sub   = 1'b0;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("sp_z",       64'(bus32.out_z),     64'h40400000);
    check("sp_flags",   64'(bus32.out_flags), 64'd0);
    check("sp_latency", 64'(lat),             64'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
